// File: rtl/prog_delay_line_pkg.sv
// Shared constants and helpers for the programmable delay line.
package prog_delay_line_pkg;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_MAX_DELAY = 8;
  localparam int unsigned DEF_CNT_W     = 8;

  // Popcount operand width; MAX_DELAY must not exceed this.
  localparam int unsigned POP_W = 64;

  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_dly);
    return (req > max_dly) ? max_dly : req;
  endfunction

  function automatic logic [7:0] popcount(input logic [POP_W-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      c = c + {7'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// Data/config/status bundle of the delay line; slave = delay line side.
interface prog_delay_line_if
  import prog_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
    parameter int unsigned CNT_W     = DEF_CNT_W
);
    localparam int unsigned DLY_W = $clog2(MAX_DELAY + 1);

    logic             en;
    logic [WIDTH-1:0] in;
    logic [DLY_W-1:0] cfg_delay;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;
    logic             flush;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output en, in, cfg_delay,
        input  out, out_valid, busy, flush, drop_cnt
    );

    modport slave (
        input  en, in, cfg_delay,
        output out, out_valid, busy, flush, drop_cnt
    );

endinterface

// File: rtl/prog_delay_line_stage_chain.sv
// Valid+data shift register exposing every stage; clr_i wipes valid bits.
module delay_stage_chain
  import prog_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_DELAY = DEF_MAX_DELAY
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr_i,
    input  logic                              tap0_valid_i,
    input  logic [WIDTH-1:0]                  tap0_data_i,
    output logic [MAX_DELAY:1]                valid_o,
    output logic [MAX_DELAY:1][WIDTH-1:0]     data_o
);

    logic [MAX_DELAY:1]            valid_q, valid_d;
    logic [MAX_DELAY:1][WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = '0;
        data_d  = data_q;
        data_d[1] = tap0_data_i;
        for (int unsigned i = 2; i <= MAX_DELAY; i++) begin
            data_d[i] = data_q[i-1];
        end
        if (!clr_i) begin
            valid_d[1] = tap0_valid_i;
            for (int unsigned i = 2; i <= MAX_DELAY; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line; a delay change flushes and counts in-flight words.
module prog_delay_line
  import prog_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    prog_delay_line_if.slave  bus
);

    localparam int unsigned DLY_W = $clog2(MAX_DELAY + 1);

    logic                          en_q;
    logic [WIDTH-1:0]              in_q;
    logic [DLY_W-1:0]              cfg_q, cfg_d, cfg_req;
    logic                          change;
    logic [MAX_DELAY:1]            stage_valid;
    logic [MAX_DELAY:1][WIDTH-1:0] stage_data;
    logic [MAX_DELAY:0]            tap_valid;
    logic [MAX_DELAY:0][WIDTH-1:0] tap_data;
    logic [MAX_DELAY:1]            drop_mask;
    logic [7:0]                    drop_pop;
    logic [CNT_W+7:0]              drop_sum;
    logic                          busy_stage;
    logic [WIDTH-1:0]              out_q, out_d;
    logic                          out_valid_q, out_valid_d;
    logic                          flush_q, flush_d;
    logic [CNT_W-1:0]              drop_cnt_q, drop_cnt_d;

    assign cfg_req = DLY_W'(clamp_delay(32'(bus.cfg_delay), MAX_DELAY));
    assign change  = (cfg_req != cfg_q);

    delay_stage_chain #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (MAX_DELAY)
    ) u_chain (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (change),
        .tap0_valid_i (en_q),
        .tap0_data_i  (in_q),
        .valid_o      (stage_valid),
        .data_o       (stage_data)
    );

    assign tap_valid = {stage_valid, en_q};
    assign tap_data  = {stage_data, in_q};

    // Stages up to the current tap hold undelivered words: they make us busy
    // and are what a flush discards.
    always_comb begin
        drop_mask  = '0;
        busy_stage = 1'b0;
        for (int unsigned i = 1; i <= MAX_DELAY; i++) begin
            if (i <= 32'(cfg_q)) begin
                drop_mask[i] = stage_valid[i];
                busy_stage   = busy_stage | stage_valid[i];
            end
        end
    end

    assign drop_pop = popcount(POP_W'(drop_mask));
    assign drop_sum = {8'b0, drop_cnt_q} + {{CNT_W{1'b0}}, drop_pop};

    always_comb begin
        cfg_d       = cfg_q;
        out_d       = out_q;
        out_valid_d = tap_valid[cfg_q];
        flush_d     = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        if (change) begin
            cfg_d       = cfg_req;
            out_valid_d = 1'b0;
            flush_d     = 1'b1;
            drop_cnt_d  = (|drop_sum[CNT_W+7:CNT_W]) ? '1 : drop_sum[CNT_W-1:0];
        end else if (tap_valid[cfg_q]) begin
            out_d = tap_data[cfg_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            cfg_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            flush_q     <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            en_q        <= bus.en;
            cfg_q       <= cfg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            flush_q     <= flush_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        in_q <= bus.in;
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = en_q | busy_stage;
    assign bus.flush     = flush_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: latency, clamping, flush accounting, saturation, reset.
module tb_prog_delay_line;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned MAX_DELAY = 8;
    localparam int unsigned CNT_W     = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    prog_delay_line_if #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W)) bus ();

    prog_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.in = 4'h0;
        bus.cfg_delay = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out, bus.out_valid, bus.busy, bus.flush, bus.drop_cnt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: out=%h ov=%b busy=%b flush=%b drop=%0d, expected all zero",
                     bus.out, bus.out_valid, bus.busy, bus.flush, bus.drop_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_delay3();
        logic [3:0] exp_out;
        logic       exp_ov, exp_busy;
        bus.cfg_delay = 4'd3;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1 || bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL first_cfg_flush: flush=%b drop=%0d, expected flush=1 drop=0", bus.flush, bus.drop_cnt);
        end
        for (int c = 0; c < 8; c++) begin
            exp_ov   = (c == 5);
            exp_out  = (c >= 5) ? 4'hA : 4'h0;
            exp_busy = (c >= 1 && c <= 4);
            checks++;
            if (bus.out_valid !== exp_ov || bus.out !== exp_out || bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL single_k3 c=%0d: ov=%b out=%h busy=%b, expected ov=%b out=%h busy=%b",
                         c, bus.out_valid, bus.out, bus.busy, exp_ov, exp_out, exp_busy);
            end
            bus.en = (c == 0);
            bus.in = 4'hA;
            @(negedge clk);
        end
    endtask

    task automatic test_burst_delay0();
        logic [3:0] exp_out;
        logic       exp_ov;
        bus.cfg_delay = 4'd0;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            exp_ov  = (c >= 2 && c <= 5);
            exp_out = (c < 2) ? 4'hA : ((c <= 5) ? 4'(c - 1) : 4'h4);
            checks++;
            if (bus.out_valid !== exp_ov || bus.out !== exp_out) begin
                errors++;
                $display("FAIL burst_k0 c=%0d: ov=%b out=%h, expected ov=%b out=%h",
                         c, bus.out_valid, bus.out, exp_ov, exp_out);
            end
            bus.en = (c <= 3);
            bus.in = 4'(c + 1);
            @(negedge clk);
        end
    endtask

    task automatic test_clamp();
        logic [3:0] exp_out;
        logic       exp_ov;
        bus.cfg_delay = 4'd12;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL clamp_enter_flush: flush=%b, expected 1", bus.flush);
        end
        bus.cfg_delay = 4'd15;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL clamp_15_noflush: flush=%b, expected 0", bus.flush);
        end
        bus.cfg_delay = 4'd9;
        @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            exp_ov  = (c == 10);
            exp_out = (c >= 10) ? 4'h7 : 4'h4;
            checks++;
            if (bus.out_valid !== exp_ov || bus.out !== exp_out || bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL clamp_latency c=%0d: ov=%b out=%h flush=%b, expected ov=%b out=%h flush=0",
                         c, bus.out_valid, bus.out, bus.flush, exp_ov, exp_out);
            end
            bus.en = (c == 0);
            bus.in = 4'h7;
            if (c == 3) bus.cfg_delay = 4'd13;
            if (c == 6) bus.cfg_delay = 4'd9;
            @(negedge clk);
        end
    endtask

    task automatic test_flush_drop();
        logic       exp_flush;
        logic [7:0] exp_drop;
        bus.cfg_delay = 4'd5;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            exp_flush = (c == 5);
            exp_drop  = (c >= 5) ? 8'd3 : 8'd0;
            checks++;
            if (bus.flush !== exp_flush || bus.drop_cnt !== exp_drop ||
                bus.out_valid !== 1'b0 || bus.out !== 4'h7) begin
                errors++;
                $display("FAIL flush_drop c=%0d: flush=%b drop=%0d ov=%b out=%h, expected flush=%b drop=%0d ov=0 out=7",
                         c, bus.flush, bus.drop_cnt, bus.out_valid, bus.out, exp_flush, exp_drop);
            end
            bus.en = (c <= 2);
            bus.in = 4'(4'hB + c);
            bus.cfg_delay = (c >= 4) ? 4'd1 : 4'd5;
            @(negedge clk);
        end
    endtask

    task automatic test_change_edge_word();
        logic       exp_flush, exp_ov;
        logic [7:0] exp_drop;
        logic [3:0] exp_out;
        bus.cfg_delay = 4'd5;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            exp_flush = (c == 4);
            exp_drop  = (c >= 4) ? 8'd5 : 8'd3;
            exp_ov    = (c == 6);
            exp_out   = (c >= 6) ? 4'hE : 4'h7;
            checks++;
            if (bus.flush !== exp_flush || bus.drop_cnt !== exp_drop ||
                bus.out_valid !== exp_ov || bus.out !== exp_out) begin
                errors++;
                $display("FAIL change_edge c=%0d: flush=%b drop=%0d ov=%b out=%h, expected flush=%b drop=%0d ov=%b out=%h",
                         c, bus.flush, bus.drop_cnt, bus.out_valid, bus.out, exp_flush, exp_drop, exp_ov, exp_out);
            end
            bus.en = (c == 0 || c == 1 || c == 3);
            bus.in = (c == 3) ? 4'hE : 4'(c + 2);
            bus.cfg_delay = (c >= 3) ? 4'd1 : 4'd5;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bus.cfg_delay = 4'd2;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: flush=%b, expected 1", bus.flush);
        end
        bus.cfg_delay = 4'd3;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: flush=%b, expected 1", bus.flush);
        end
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b0 || bus.drop_cnt !== 8'd5) begin
            errors++;
            $display("FAIL b2b_settle: flush=%b drop=%0d, expected flush=0 drop=5", bus.flush, bus.drop_cnt);
        end
    endtask

    task automatic test_saturate();
        bus.cfg_delay = 4'd8;
        bus.en = 1'b1;
        bus.in = 4'h5;
        repeat (10) @(negedge clk);
        bus.cfg_delay = 4'd7;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1 || bus.drop_cnt !== 8'd13) begin
            errors++;
            $display("FAIL full_chain_drop: flush=%b drop=%0d, expected flush=1 drop=13", bus.flush, bus.drop_cnt);
        end
        for (int r = 0; r < 40; r++) begin
            bus.cfg_delay = (r % 2 == 0) ? 4'd8 : 4'd7;
            repeat (10) @(negedge clk);
        end
        checks++;
        if (bus.drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturate: drop=%0d, expected 255", bus.drop_cnt);
        end
        bus.cfg_delay = 4'd8;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturate_hold: drop=%0d, expected 255", bus.drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: busy=%b, expected 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out, bus.out_valid, bus.busy, bus.flush, bus.drop_cnt} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: out=%h ov=%b busy=%b flush=%b drop=%0d, expected all zero",
                     bus.out, bus.out_valid, bus.busy, bus.flush, bus.drop_cnt);
        end
        @(negedge clk);
        bus.en = 1'b0;
        bus.cfg_delay = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.cfg_delay = 4'd4;
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b1 || bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_flush: flush=%b drop=%0d, expected flush=1 drop=0", bus.flush, bus.drop_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_settle: flush=%b, expected 0", bus.flush);
        end
    endtask

    initial begin
        test_reset();
        test_single_delay3();
        test_burst_delay0();
        test_clamp();
        test_flush_drop();
        test_change_edge_word();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
